dot_acc_seq: RTL and testbench
==============================

DOT_ACC_SEQ -- requirements
Module: dot_acc_seq

Interface
REQ-001 SHALL have parameter exp_width, default 4, element exponent width.
REQ-002 SHALL have parameter man_width, default 3, element mantissa width.
REQ-003 SHALL have parameter k, default 32, lanes per chunk, equal to the attached dot unit's k.
REQ-004 SHALL have parameter max_chunks, default 16, maximum chunks per accumulation.
REQ-005 Derived widths: bit_width = 1+exp_width+man_width; dp_width = 2*((1<<exp_width)+man_width) + $clog2(k); acc_width = dp_width + $clog2(max_chunks).
REQ-006 clk  input  1  clock, all state on rising edge.
REQ-007 rst  input  1  asynchronous, active-high reset.
REQ-008 i_vec_a, i_vec_b  input  bit_width x k each  chunk operands.
REQ-009 i_valid  input  1  chunk present; i_last  input  1  final chunk of this dot product.
REQ-010 o_ready  output  1  chunk accepted when i_valid && o_ready.
REQ-011 o_vec_a, o_vec_b  output  bit_width x k each  registered operands driven to the external combinational dot unit.
REQ-012 i_dp  input  dp_width signed  dot unit result for o_vec_a/o_vec_b, valid in the same cycle.
REQ-013 i_flush  input  1  synchronous abort.
REQ-014 o_sum  output  acc_width signed  accumulated result; o_count  output  $clog2(max_chunks)+1  chunks summed; o_trunc  output  1  forced termination flag.
REQ-015 o_valid  output  1  result present; i_ready  input  1  result consumed when o_valid && i_ready.

Function
REQ-016 SHALL implement states LOAD, WAIT, DONE.
REQ-017 o_ready SHALL be 1 only in LOAD; o_valid SHALL be 1 only in DONE.
REQ-018 Accepted chunk SHALL be registered into o_vec_a/o_vec_b with stage flags s1_valid, s1_first, s1_last on the accepting edge; s1_valid SHALL be 0 on edges with no acceptance.
REQ-019 When s1_valid, acc SHALL update on the next edge: acc = sext(i_dp) if s1_first, else acc + sext(i_dp); no wrap for legal inputs.
REQ-020 s1_first SHALL be set for the first chunk accepted after reset, flush or a DONE handshake.
REQ-021 An internal chunk counter SHALL increment per accepted chunk; o_count SHALL equal the number of chunks summed into o_sum.
REQ-022 Accepted chunk with i_last=1, or the max_chunks-th chunk, SHALL set s1_last and move LOAD -> WAIT.
REQ-023 Termination by the max_chunks-th chunk with i_last=0 SHALL set o_trunc=1 for that result; otherwise o_trunc=0.
REQ-024 WAIT -> DONE on the edge that accumulates the s1_last chunk; the result SHALL be visible on o_sum with o_valid=1 two edges after the last chunk is accepted.
REQ-025 DONE -> LOAD on o_valid && i_ready; o_sum, o_count, o_trunc SHALL hold stable while o_valid && !i_ready.
REQ-026 Back-to-back chunks SHALL be accepted every cycle in LOAD; n chunks SHALL yield o_valid n+1 edges after the first acceptance.
REQ-027 i_flush SHALL, from any state, force LOAD, clear s1_valid, counter, o_trunc, and mark the next chunk as first; i_flush has priority over acceptance and handshake in the same cycle.
REQ-028 i_last on a non-accepted cycle (o_ready=0 or i_valid=0) SHALL be ignored.

Reset
REQ-029 rst SHALL asynchronously force LOAD, o_valid=0, o_ready=1 once released, o_sum=0, o_count=0, o_trunc=0, o_vec_a/o_vec_b=0, s1_valid=0.
REQ-030 rst asserted mid-accumulation SHALL discard all partial state; the first chunk after release SHALL be treated as first.

Verification
REQ-031 Three chunks, all elements 0x01 (i_dp=32 each), last on third, i_ready=1 -> o_sum=96, o_count=3, o_trunc=0, o_valid 4 edges after first acceptance.
REQ-032 One chunk, all elements 0x38 (1.0 x 1.0) with i_last=1 -> o_sum=8388608, o_count=1, o_valid for one cycle.
REQ-033 16 chunks of 0x01, i_last never set -> o_sum=512, o_count=16, o_trunc=1, o_ready=0 after 16th chunk.
REQ-034 Result with i_ready=0 for 5 cycles -> o_sum/o_count stable, o_ready=0, i_valid chunks not accepted; next dot after handshake starts from 0.
REQ-035 Two chunks accepted, then i_flush -> no o_valid; next single 0x01 chunk with i_last -> o_sum=32, o_count=1.
REQ-036 rst pulsed during WAIT -> all outputs at reset values immediately, no o_valid for the aborted dot.

Source files
------------

// File: rtl/dot_acc_seq.sv
// Chunked dot-product accumulator: feeds an external combinational dot unit
// and sums its per-chunk results into one signed total per dot product.
module dot_acc_seq #(
    parameter int exp_width  = 4,
    parameter int man_width  = 3,
    parameter int k          = 32,
    parameter int max_chunks = 16,
    localparam int bit_width = 1 + exp_width + man_width,
    localparam int dp_width  = 2 * ((1 << exp_width) + man_width) + $clog2(k),
    localparam int acc_width = dp_width + $clog2(max_chunks),
    localparam int cnt_width = $clog2(max_chunks) + 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [bit_width*k-1:0]      i_vec_a,
    input  logic [bit_width*k-1:0]      i_vec_b,
    input  logic                        i_valid,
    input  logic                        i_last,
    output logic                        o_ready,
    output logic [bit_width*k-1:0]      o_vec_a,
    output logic [bit_width*k-1:0]      o_vec_b,
    input  logic signed [dp_width-1:0]  i_dp,
    input  logic                        i_flush,
    output logic signed [acc_width-1:0] o_sum,
    output logic [cnt_width-1:0]        o_count,
    output logic                        o_trunc,
    output logic                        o_valid,
    input  logic                        i_ready
);

    typedef enum logic [1:0] {
        LOAD,
        WAIT,
        DONE
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [bit_width*k-1:0]      r_vec_a;
    logic [bit_width*k-1:0]      r_vec_b;
    logic                        r_s1_valid;
    logic                        r_s1_first;
    logic                        r_s1_last;
    logic signed [acc_width-1:0] r_acc;
    logic [cnt_width-1:0]        r_cnt;
    logic [cnt_width-1:0]        r_sum_cnt;
    logic                        r_trunc;

    logic                        w_accept;
    logic                        w_hs;
    logic [cnt_width-1:0]        w_cnt_next;
    logic                        w_hit_max;
    logic                        w_last;
    logic signed [acc_width-1:0] w_dp_ext;

    // Flush wins over both acceptance and the result handshake.
    assign w_accept   = i_valid && (r_state == LOAD) && !i_flush;
    assign w_hs       = i_ready && (r_state == DONE) && !i_flush;
    assign w_cnt_next = r_cnt + cnt_width'(1);
    assign w_hit_max  = (w_cnt_next == cnt_width'(max_chunks));
    assign w_last     = i_last || w_hit_max;
    assign w_dp_ext   = {{(acc_width - dp_width){i_dp[dp_width-1]}}, i_dp};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= LOAD;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        o_ready      = 1'b0;
        o_valid      = 1'b0;
        unique case (r_state)
            LOAD: begin
                o_ready = 1'b1;
                if (w_accept && w_last) begin
                    w_state_next = WAIT;
                end
            end
            WAIT: begin
                if (r_s1_valid && r_s1_last) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                o_valid = 1'b1;
                if (i_ready) begin
                    w_state_next = LOAD;
                end
            end
            default: w_state_next = LOAD;
        endcase
        if (i_flush) begin
            w_state_next = LOAD;
        end
    end

    // A zero chunk counter marks the next accepted chunk as the first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vec_a    <= '0;
            r_vec_b    <= '0;
            r_s1_valid <= 1'b0;
            r_s1_first <= 1'b0;
            r_s1_last  <= 1'b0;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_sum_cnt  <= '0;
            r_trunc    <= 1'b0;
        end else if (i_flush) begin
            r_s1_valid <= 1'b0;
            r_cnt      <= '0;
            r_trunc    <= 1'b0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_vec_a    <= i_vec_a;
                r_vec_b    <= i_vec_b;
                r_s1_first <= (r_cnt == '0);
                r_s1_last  <= w_last;
                r_cnt      <= w_cnt_next;
                if (w_last) begin
                    r_trunc <= w_hit_max && !i_last;
                end
            end
            if (r_s1_valid) begin
                if (r_s1_first) begin
                    r_acc     <= w_dp_ext;
                    r_sum_cnt <= cnt_width'(1);
                end else begin
                    r_acc     <= r_acc + w_dp_ext;
                    r_sum_cnt <= r_sum_cnt + cnt_width'(1);
                end
            end
            if (w_hs) begin
                r_cnt <= '0;
            end
        end
    end

    assign o_vec_a = r_vec_a;
    assign o_vec_b = r_vec_b;
    assign o_sum   = r_acc;
    assign o_count = r_sum_cnt;
    assign o_trunc = r_trunc;

endmodule

// File: tb/tb_dot_acc_seq.sv
// Randomized bench for dot_acc_seq: models the attached dot unit and
// predicts each dot product's total, chunk count and truncation flag.
module tb_dot_acc_seq;

    localparam int K    = 32;
    localparam int BW   = 8;
    localparam int DPW  = 43;
    localparam int ACCW = 47;
    localparam int CW   = 5;
    localparam int MAXC = 16;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [BW*K-1:0]        i_vec_a;
    logic [BW*K-1:0]        i_vec_b;
    logic                   i_valid;
    logic                   i_last;
    logic                   o_ready;
    logic [BW*K-1:0]        o_vec_a;
    logic [BW*K-1:0]        o_vec_b;
    logic signed [DPW-1:0]  i_dp;
    logic                   i_flush;
    logic signed [ACCW-1:0] o_sum;
    logic [CW-1:0]          o_count;
    logic                   o_trunc;
    logic                   o_valid;
    logic                   i_ready;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    dot_acc_seq #(
        .exp_width (4),
        .man_width (3),
        .k         (K),
        .max_chunks(MAXC)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .i_vec_a(i_vec_a),
        .i_vec_b(i_vec_b),
        .i_valid(i_valid),
        .i_last (i_last),
        .o_ready(o_ready),
        .o_vec_a(o_vec_a),
        .o_vec_b(o_vec_b),
        .i_dp   (i_dp),
        .i_flush(i_flush),
        .o_sum  (o_sum),
        .o_count(o_count),
        .o_trunc(o_trunc),
        .o_valid(o_valid),
        .i_ready(i_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Element value in units of 2^-9 (the smallest subnormal is 1).
    function automatic longint ev(input logic [7:0] x);
        longint mag;
        if (x[6:3] == 4'd0) mag = longint'(x[2:0]);
        else mag = longint'(8 + x[2:0]) <<< (x[6:3] - 1);
        return x[7] ? -mag : mag;
    endfunction

    function automatic longint dot(input logic [BW*K-1:0] a,
                                   input logic [BW*K-1:0] b);
        longint s = 0;
        for (int i = 0; i < K; i++) s += ev(a[i*BW +: BW]) * ev(b[i*BW +: BW]);
        return s;
    endfunction

    always_comb i_dp = DPW'(dot(o_vec_a, o_vec_b));

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic fill(input int mode);
        for (int i = 0; i < K; i++) begin
            case (mode)
                0: begin i_vec_a[i*BW +: BW] = 8'h01; i_vec_b[i*BW +: BW] = 8'h01; end
                1: begin i_vec_a[i*BW +: BW] = 8'h38; i_vec_b[i*BW +: BW] = 8'h38; end
                default: begin
                    i_vec_a[i*BW +: BW] = 8'($urandom);
                    i_vec_b[i*BW +: BW] = 8'($urandom);
                end
            endcase
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One dot product of n requested chunks; beyond MAXC the block truncates.
    task automatic run_dot(input int n, input int mode, input bit gaps,
                           input bit rdy);
        longint          exp_sum = 0;
        int              nsend   = (n > MAXC) ? MAXC : n;
        bit              lastf   = (n <= MAXC);
        int              c_first = 0;
        int              c_last  = 0;
        int              w       = 0;
        logic [BW*K-1:0] last_a  = '0;
        i_ready = rdy;
        for (int i = 0; i < nsend; i++) begin
            if (gaps) begin
                while ($urandom_range(0, 2) == 0) begin
                    i_valid = 1'b0;
                    i_last  = 1'($urandom);
                    fill(2);
                    tick();
                end
            end
            fill(mode);
            i_valid = 1'b1;
            i_last  = lastf && (i == nsend - 1);
            exp_sum += dot(i_vec_a, i_vec_b);
            last_a  = i_vec_a;
            chk("ready_load", o_ready, 1);
            tick();
            if (i == 0) c_first = cyc;
            c_last = cyc;
        end
        i_valid = 1'b0;
        i_last  = 1'b0;
        chk("ready_after_last", o_ready, 0);
        while (!o_valid && w < 20) begin
            tick();
            w++;
        end
        chk("valid_seen", o_valid, 1);
        chk("lat_last", cyc - c_last, 1);
        if (!gaps) chk("lat_first", cyc - c_first, nsend);
        chk("sum", o_sum, exp_sum);
        chk("count", o_count, nsend);
        chk("trunc", o_trunc, (n > MAXC));
        if (!rdy) begin
            for (int s = 0; s < 5; s++) begin
                i_valid = 1'b1;
                i_last  = 1'($urandom);
                fill(2);
                tick();
                chk("stall_valid", o_valid, 1);
                chk("stall_ready", o_ready, 0);
                chk("stall_sum", o_sum, exp_sum);
                chk("stall_count", o_count, nsend);
                chk("stall_vec", (o_vec_a == last_a), 1);
            end
            i_valid = 1'b0;
            i_last  = 1'b0;
            i_ready = 1'b1;
        end
        tick();
        chk("valid_drop", o_valid, 0);
        chk("ready_back", o_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst     = 1'b1;
        i_valid = 1'b0;
        i_last  = 1'b0;
        i_flush = 1'b0;
        i_ready = 1'b1;
        i_vec_a = '0;
        i_vec_b = '0;
        repeat (3) tick();
        chk("rst_valid", o_valid, 0);
        chk("rst_sum", o_sum, 0);
        chk("rst_count", o_count, 0);
        chk("rst_trunc", o_trunc, 0);
        chk("rst_vec", (o_vec_a == '0 && o_vec_b == '0), 1);
        rst = 1'b0;
        tick();
        chk("rst_ready", o_ready, 1);

        run_dot(3, 0, 1'b0, 1'b1);
        run_dot(1, 1, 1'b0, 1'b1);
        run_dot(20, 0, 1'b0, 1'b1);
        run_dot(16, 2, 1'b0, 1'b1);
        run_dot(2, 2, 1'b0, 1'b0);
        run_dot(1, 0, 1'b0, 1'b1);

        // Abort after two chunks; the chunk offered with the flush is dropped.
        fill(0);
        i_valid = 1'b1;
        i_last  = 1'b0;
        repeat (2) tick();
        fill(2);
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        i_valid = 1'b0;
        for (int s = 0; s < 4; s++) begin
            chk("flush_novalid", o_valid, 0);
            chk("flush_ready", o_ready, 1);
            tick();
        end
        run_dot(1, 0, 1'b0, 1'b1);

        // Asynchronous reset while the last chunk waits for accumulation.
        fill(2);
        i_valid = 1'b1;
        i_last  = 1'b1;
        tick();
        i_valid = 1'b0;
        i_last  = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("arst_valid", o_valid, 0);
        chk("arst_sum", o_sum, 0);
        chk("arst_count", o_count, 0);
        chk("arst_trunc", o_trunc, 0);
        chk("arst_vec", (o_vec_a == '0 && o_vec_b == '0), 1);
        #1 rst = 1'b0;
        for (int s = 0; s < 4; s++) begin
            tick();
            chk("arst_novalid", o_valid, 0);
            chk("arst_ready", o_ready, 1);
        end

        for (int t = 0; t < 14; t++) begin
            run_dot(int'($urandom_range(1, 20)), 2, 1'($urandom), 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
